dmem_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single-ported data memory (1024 × 32-bit words, byte-write enables, registered read data one cycle after the address edge) between two requesters. Port 0 is the CPU load/store unit; port 1 is a debug/DMA master.
- Accepts at most one access per cycle and presents it combinationally on the memory bus.
- Returns read data to the requester that issued it, one cycle later, tagged with `rvalid`.
- Flags out-of-range accesses with `err` instead of performing them.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/rr_arb2.sv | 30 +++
 rtl/dmem_arbiter.sv | 96 +++++++++
 tb/tb_dmem_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and response tag for the two-port data memory arbiter.
package dmem_pkg;
    localparam int unsigned DEF_MEM_BYTES = 4096;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
        logic is_read;
        logic err;
    } rsp_tag_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the port that did not win last gets the tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);
    logic last_gnt;

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Reset to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_gnt <= 1'b1;
        else if (accept)
            last_gnt <= gnt[1];
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-ported data memory between the CPU LSU (port 0) and a
// debug/DMA master (port 1); one access per cycle, 1-cycle read latency.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = DEF_MEM_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_wdata_sel,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_wdata_sel,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wdata_sel,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    logic [1:0] req;
    logic [1:0] gnt;
    logic       accept;
    logic       sel;
    logic       sel_we;
    logic       in_range;
    rsp_tag_t   rsp_d;
    rsp_tag_t   rsp_q;

    assign req = {m1_req, m0_req};

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .accept (accept),
        .gnt    (gnt)
    );

    assign accept = |(req & gnt);
    assign sel    = gnt[PORT_DBG];
    assign m0_gnt = gnt[PORT_CPU];
    assign m1_gnt = gnt[PORT_DBG];

    // With no grant sel is 0, so the bus idles on the port 0 fields.
    always_comb begin
        mem_addr      = m0_addr;
        mem_wdata_sel = m0_wdata_sel;
        mem_wdata     = m0_wdata;
        sel_we        = m0_we;
        if (sel) begin
            mem_addr      = m1_addr;
            mem_wdata_sel = m1_wdata_sel;
            mem_wdata     = m1_wdata;
            sel_we        = m1_we;
        end
    end

    assign in_range = (mem_addr < MEM_BYTES);
    assign mem_we   = accept && sel_we && in_range;

    always_comb begin
        rsp_d         = '0;
        rsp_d.valid   = accept;
        rsp_d.port    = sel;
        rsp_d.is_read = !sel_we;
        rsp_d.err     = !in_range;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rsp_q <= '0;
        else
            rsp_q <= rsp_d;
    end

    assign m0_rvalid = rsp_q.valid && (rsp_q.port == PORT_CPU) && rsp_q.is_read && !rsp_q.err;
    assign m1_rvalid = rsp_q.valid && (rsp_q.port == PORT_DBG) && rsp_q.is_read && !rsp_q.err;
    assign m0_err    = rsp_q.valid && (rsp_q.port == PORT_CPU) && rsp_q.err;
    assign m1_err    = rsp_q.valid && (rsp_q.port == PORT_DBG) && rsp_q.err;
    assign m0_rdata  = m0_rvalid ? mem_rdata : 32'h0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : 32'h0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory, per-cycle model compare and
// directed vectors with literal expectations.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wdata_sel, m1_wdata_sel;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wdata_sel;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram    [0:1023] = '{default: '0};
    logic [31:0] shadow [0:1023];

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_BYTES(4096)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata_sel(m0_wdata_sel),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_err(m0_err),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata_sel(m1_wdata_sel),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_err(m1_err),
        .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata_sel(mem_wdata_sel),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Single-ported memory with registered read data.
    always @(posedge clk) begin
        if (mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_wdata_sel[b]) ram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        mem_rdata <= ram[mem_addr[11:2]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: who should win, what goes on the bus, and what each port sees next cycle.
    initial begin : model
        logic        prefer1;
        logic        win_valid, win;
        logic [31:0] a, d;
        logic [3:0]  s;
        logic        w;
        logic [1:0]  exp_rv, exp_er;
        logic [31:0] exp_rd [2];
        for (int i = 0; i < 1024; i++) shadow[i] = '0;
        prefer1 = 1'b0;
        exp_rv = '0; exp_er = '0; exp_rd[0] = '0; exp_rd[1] = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prefer1 = 1'b0;
                exp_rv = '0; exp_er = '0; exp_rd[0] = '0; exp_rd[1] = '0;
            end
            win_valid = !rst && (m0_req || m1_req);
            win = (m0_req && m1_req) ? prefer1 : m1_req;
            a = win ? m1_addr : m0_addr;
            d = win ? m1_wdata : m0_wdata;
            s = win ? m1_wdata_sel : m0_wdata_sel;
            w = win ? m1_we : m0_we;

            chk("m0_gnt", m0_gnt, win_valid && !win);
            chk("m1_gnt", m1_gnt, win_valid && win);
            chk("mem_addr", mem_addr, win_valid ? a : m0_addr);
            chk("mem_we", mem_we, win_valid && w && (a < 4096));
            if (mem_we) chk("mem_wdata", mem_wdata, d);
            chk("m0_rvalid", m0_rvalid, exp_rv[0]);
            chk("m1_rvalid", m1_rvalid, exp_rv[1]);
            chk("m0_err", m0_err, exp_er[0]);
            chk("m1_err", m1_err, exp_er[1]);
            chk("m0_rdata", m0_rdata, exp_rd[0]);
            chk("m1_rdata", m1_rdata, exp_rd[1]);

            exp_rv = '0; exp_er = '0; exp_rd[0] = '0; exp_rd[1] = '0;
            if (win_valid) begin
                if (a >= 4096) exp_er[win] = 1'b1;
                else if (!w) begin
                    exp_rv[win] = 1'b1;
                    exp_rd[win] = shadow[a[11:2]];
                end else
                    for (int b = 0; b < 4; b++)
                        if (s[b]) shadow[a[11:2]][8*b +: 8] = d[8*b +: 8];
                prefer1 = !win;
            end
        end
    end

    task automatic set0(input logic r, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d);
        m0_req = r; m0_we = w; m0_addr = a; m0_wdata_sel = s; m0_wdata = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d);
        m1_req = r; m1_we = w; m1_addr = a; m1_wdata_sel = s; m1_wdata = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int cnt;
        set0(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        set1(1'b1, 1'b0, 32'h4, 4'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        tick;
        rst = 1'b0;
        set0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick;

        // write then read-after-write from the other port
        set0(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        chk("raw_m0_gnt", m0_gnt, 1);
        chk("raw_mem_we", mem_we, 1);
        tick;
        set0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set1(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        @(negedge clk);
        chk("raw_m1_gnt", m1_gnt, 1);
        chk("raw_no_wr_rsp", m0_rvalid, 0);
        tick;
        set1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("raw_m1_rvalid", m1_rvalid, 1);
        chk("raw_m1_rdata", m1_rdata, 32'hDEADBEEF);
        chk("raw_m0_rvalid", m0_rvalid, 0);
        tick;

        // continuous contention alternates, starting with port 0
        set0(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        set1(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("tie_m0_gnt", m0_gnt, (i % 2) == 0);
            chk("tie_m1_rvalid", m1_rvalid, (i > 0) && ((i % 2) == 0));
            tick;
        end
        set0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("tie_last_rvalid", m1_rvalid, 1);
        tick;

        // partial byte write
        set0(1'b1, 1'b1, 32'h20, 4'hF, 32'h11223344);
        tick;
        set0(1'b1, 1'b1, 32'h20, 4'b0100, 32'h00AB0000);
        tick;
        set0(1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
        tick;
        set0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("bytesel_rdata", m0_rdata, 32'h11AB3344);
        tick;

        // out-of-range write and read
        set1(1'b1, 1'b1, 32'h1000, 4'hF, 32'hCAFEF00D);
        @(negedge clk);
        chk("oor_mem_we", mem_we, 0);
        tick;
        set1(1'b1, 1'b0, 32'hFFFFFFFC, 4'h0, 32'h0);
        @(negedge clk);
        chk("oor_wr_err", m1_err, 1);
        tick;
        set1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        set0(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("oor_rd_err", m1_err, 1);
        chk("oor_rd_rvalid", m1_rvalid, 0);
        tick;
        set0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("oor_mem_intact", m0_rdata, 32'h0);
        tick;

        // reset with a read in flight
        set0(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        @(negedge clk);
        chk("rstmid_gnt", m0_gnt, 1);
        #2 rst = 1'b1;
        set0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick;
        @(negedge clk);
        chk("rstmid_rvalid", m0_rvalid, 0);
        tick;
        rst = 1'b0;
        set0(1'b1, 1'b0, 32'h14, 4'h0, 32'h0);
        set1(1'b1, 1'b0, 32'h18, 4'h0, 32'h0);
        @(negedge clk);
        chk("rstmid_tie_m0", m0_gnt, 1);
        chk("rstmid_no_rv", m0_rvalid, 0);
        tick;
        set0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick;
        set1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick;
        tick;

        // fill 8 words back-to-back, then burst-read them from port 1
        for (int i = 0; i < 8; i++) begin
            set0(1'b1, 1'b1, 32'h40 + 32'(4 * i), 4'hF, 32'hA500 + 32'(i));
            tick;
        end
        set0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            set1(1'b1, 1'b0, 32'h40 + 32'(4 * i), 4'h0, 32'h0);
            @(negedge clk);
            if (m1_rvalid) cnt++;
            chk("burst_gnt", m1_gnt, 1);
            tick;
        end
        set1(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        if (m1_rvalid) cnt++;
        chk("burst_last_rdata", m1_rdata, 32'hA507);
        chk("burst_count", cnt, 8);
        tick;
        tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
